dbus_arbiter: RTL

- Shares the single core data bus between NUM_MASTERS requesters: master 0 = LSU, 1 = MMU page-table walker, 2 = debug/system-bus access.
- Sits between the requesters and dbus_interconnect.
- Round-robin grant, locked until the transaction is acknowledged.
- Forwards the request of one master at a time and routes the response back only to that master.

---
 rtl/dbus_arbiter_pkg.sv | 33 +++
 rtl/dbus_arbiter_rr_arbiter.sv | 35 +++
 rtl/dbus_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dbus_arbiter_pkg.sv
// Shared types and constants for the core data-bus arbiter.
// Covers the requester/bus request and response structs, the arbiter
// state encoding and the fixed master index assignment.
package dbus_arbiter_pkg;

    localparam int DBUS_NUM_MASTERS = 3;
    localparam int DBUS_MASTER_LSU  = 0;
    localparam int DBUS_MASTER_PTW  = 1;
    localparam int DBUS_MASTER_DBG  = 2;

    typedef struct packed {
        logic        ld_req;
        logic        st_req;
        logic [31:0] addr;
        logic [31:0] w_data;
        logic [3:0]  st_ops;
    } type_lsu2dbus_s;

    typedef struct packed {
        logic [31:0] r_data;
        logic        ack;
    } type_dbus2lsu_s;

    typedef enum logic {
        DBUS_ARB_IDLE = 1'b0,
        DBUS_ARB_BUSY = 1'b1
    } type_dbus_arb_states_e;

    function automatic logic is_requesting(input type_lsu2dbus_s r);
        return r.ld_req | r.st_req;
    endfunction

endpackage

// File: rtl/dbus_arbiter_rr_arbiter.sv
// Combinational rotate-priority picker. Scans last_i+1, last_i+2, ...
// modulo N and returns the first requester as one-hot and as an index.
// Kept free of bus types so the instruction-bus side can reuse it.
module dbus_arbiter_rr_arbiter #(
    parameter int N = 3,
    localparam int LW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [LW-1:0] last_i,
    output logic [N-1:0]  pick_o,
    output logic [LW-1:0] pick_idx_o,
    output logic          valid_o
);

    // First requester after the previous winner, wrapping around.
    always_comb begin
        int              idx_int;
        logic [LW-1:0]   idx;
        pick_o     = '0;
        pick_idx_o = '0;
        valid_o    = 1'b0;
        idx_int    = 0;
        idx        = '0;
        for (int k = 1; k <= N; k++) begin
            idx_int = (int'(last_i) + k) % N;
            idx     = LW'(idx_int);
            if (!valid_o && req_i[idx]) begin
                valid_o     = 1'b1;
                pick_o[idx] = 1'b1;
                pick_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Round-robin arbiter sharing the core data bus between NUM_MASTERS
// requesters (0 = LSU, 1 = page-table walker, 2 = debug access).
// The grant is held until the transaction is acked or the owner drops
// its request; only the owner sees the bus response.
// Optional build macro DBUS_ARB_TIMEOUT_EN adds a BUSY watchdog that
// force-completes a stuck transaction after TIMEOUT_CYCLES cycles.
//
// state          | meaning
// DBUS_ARB_IDLE  | no owner; arbitrate among current requesters
// DBUS_ARB_BUSY  | owner's request forwarded, waiting for ack/drop
module dbus_arbiter
    import dbus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = DBUS_NUM_MASTERS,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                clk,
    input  logic                                rst,
    input  type_lsu2dbus_s [NUM_MASTERS-1:0]    req2arb_i,
    output type_dbus2lsu_s [NUM_MASTERS-1:0]    arb2req_o,
    output type_lsu2dbus_s                      arb2dbus_o,
    input  type_dbus2lsu_s                      dbus2arb_i,
    output logic [NUM_MASTERS-1:0]              grant_o,
    output logic                                busy_o,
    output logic                                timeout_err_o
);

    localparam int LW = $clog2(NUM_MASTERS);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("dbus_arbiter: NUM_MASTERS must be 2..8 and TIMEOUT_CYCLES at least 2");
    end

    type_dbus_arb_states_e  state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [LW-1:0]          last_q, last_d;
    logic [NUM_MASTERS-1:0] req_vec;
    logic [NUM_MASTERS-1:0] pick_oh;
    logic [LW-1:0]          pick_idx;
    logic                   pick_valid;
    logic                   to_fire;

    // Collapse each master's request struct to a single "wants the bus" bit.
    always_comb begin
        req_vec = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            req_vec[m] = is_requesting(req2arb_i[m]);
        end
    end

    dbus_arbiter_rr_arbiter #(.N(NUM_MASTERS)) u_rr (
        .req_i      (req_vec),
        .last_i     (last_q),
        .pick_o     (pick_oh),
        .pick_idx_o (pick_idx),
        .valid_o    (pick_valid)
    );

`ifdef DBUS_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] to_cnt_q, to_cnt_d;

    // Watchdog count: cleared while idle, advances on each un-acked BUSY cycle.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q == DBUS_ARB_IDLE) begin
            to_cnt_d = '0;
        end else if (!dbus2arb_i.ack) begin
            to_cnt_d = to_cnt_q + CW'(1);
        end
    end

    // Watchdog count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    // A real ack on the last allowed cycle wins over the forced completion.
    assign to_fire = (state_q == DBUS_ARB_BUSY) && (to_cnt_q == TO_LAST) && !dbus2arb_i.ack;
`else
    assign to_fire = 1'b0;
`endif

    // Next-state, grant bookkeeping and bus/response steering.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        arb2dbus_o    = '0;
        arb2req_o     = '0;
        timeout_err_o = 1'b0;
        case (state_q)
            DBUS_ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = DBUS_ARB_BUSY;
                    grant_d = pick_oh;
                    last_d  = pick_idx;
                end
            end
            DBUS_ARB_BUSY: begin
                // last_q holds the owner's index for the whole BUSY period.
                arb2dbus_o        = req2arb_i[last_q];
                arb2req_o[last_q] = dbus2arb_i;
                if (to_fire) begin
                    arb2req_o[last_q].ack    = 1'b1;
                    arb2req_o[last_q].r_data = '0;
                    timeout_err_o            = 1'b1;
                end
                if (dbus2arb_i.ack || to_fire || !req_vec[last_q]) begin
                    state_d = DBUS_ARB_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = DBUS_ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State, grant and last-winner registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DBUS_ARB_IDLE;
            grant_q <= '0;
            last_q  <= LW'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q == DBUS_ARB_BUSY);

endmodule
